// File: rtl/note_sequencer.sv
// Note-ROM driven tone sequencer: fetches {half_period, duration_ms} entries,
// hands each pitch to a square-wave generator and times the note and inter-note gap.
module note_sequencer #(
  parameter int TICK_DIV = 100000,
  parameter int GAP_MS   = 20,
  parameter int AW       = 4
) (
  input  logic          CLK100MHZ,
  input  logic          BTNC,
  input  logic          SW,
  input  logic          loop_en,
  output logic [AW-1:0] rom_addr,
  output logic          rom_rd,
  input  logic [23:0]   rom_data,
  output logic [15:0]   tone_half_period,
  output logic          tone_valid,
  input  logic          tone_ready,
  output logic          mute,
  output logic          busy,
  output logic          done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [15:0]   GAP_LAST  = 16'(GAP_MS - 1);
  localparam logic [AW-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_PLAY, S_GAP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   period_q, period_d;
  logic [7:0]    dur_q, dur_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   ms_q, ms_d;
  logic          done_q, done_d;
  logic          sw_prev_q, sw_prev_d;
  logic          advance, song_end;
  logic [15:0]   play_last;

  assign play_last = {8'd0, dur_q} - 16'd1;

  assign rom_addr         = addr_q;
  assign rom_rd           = (state_q == S_FETCH);
  assign tone_valid       = (state_q == S_ISSUE);
  assign tone_half_period = period_q;
  assign mute             = !((state_q == S_PLAY) && (period_q != 16'd0));
  assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done             = done_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can leave it unassigned and infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    period_d  = period_q;
    dur_d     = dur_q;
    presc_d   = '0;
    ms_d      = '0;
    done_d    = 1'b0;
    sw_prev_d = SW;
    advance   = 1'b0;
    song_end  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (SW && !sw_prev_q) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        period_d = rom_data[23:8];
        dur_d    = rom_data[7:0];
        if (rom_data[7:0] == 8'd0)        song_end = 1'b1;
        else if (rom_data[23:8] == 16'd0) state_d  = S_PLAY;
        else                              state_d  = S_ISSUE;
      end
      S_ISSUE: if (tone_ready) state_d = S_PLAY;
      S_PLAY: begin
        // Counters hold only while staying in the state, so every entry starts from zero.
        if (presc_q == PRESC_MAX) begin
          if (ms_q == play_last) begin
            if (GAP_MS > 0) state_d = S_GAP;
            else            advance = 1'b1;
          end else begin
            ms_d = ms_q + 16'd1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
          ms_d    = ms_q;
        end
      end
      S_GAP: begin
        if (presc_q == PRESC_MAX) begin
          if (ms_q == GAP_LAST) advance = 1'b1;
          else                  ms_d    = ms_q + 16'd1;
        end else begin
          presc_d = presc_q + PW'(1);
          ms_d    = ms_q;
        end
      end
      S_DONE: if (!SW) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (addr_q == ADDR_LAST) begin
        song_end = 1'b1;
      end else begin
        addr_d  = addr_q + AW'(1);
        state_d = S_FETCH;
      end
    end

    if (song_end) begin
      addr_d = '0;
      if (loop_en) begin
        state_d = S_FETCH;
      end else begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
    end

    // Dropping SW aborts any active state and outranks a same-cycle handshake.
    if (busy && !SW) begin
      state_d = S_IDLE;
      addr_d  = '0;
      done_d  = 1'b0;
      presc_d = '0;
      ms_d    = '0;
    end
  end

  // NOTE: reset is sampled on the clock edge, and sequential state uses <= so every flop sees pre-edge values.
  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      period_q  <= '0;
      dur_q     <= '0;
      presc_q   <= '0;
      ms_q      <= '0;
      done_q    <= 1'b0;
      sw_prev_q <= SW;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      period_q  <= period_d;
      dur_q     <= dur_d;
      presc_q   <= presc_d;
      ms_q      <= ms_d;
      done_q    <= done_d;
      sw_prev_q <= sw_prev_d;
    end
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100000, clock cycles per 1 ms duration tick (100 MHz clock).
REQ-002 Parameter GAP_MS, default 20, silent gap between notes, in ms ticks; 0 means no gap.
REQ-003 Parameter AW, default 4, note-ROM address width; song length SHALL be 2**AW entries.
REQ-004 CLK100MHZ  input  1  sole clock; all logic on its rising edge.
REQ-005 BTNC  input  1  reset, synchronous, active-high.
REQ-006 SW  input  1  play enable; a 0->1 edge in IDLE starts playback, low aborts.
REQ-007 loop_en  input  1  1 = restart at address 0 after end of song.
REQ-008 rom_addr  output  AW  note-ROM read address.
REQ-009 rom_rd  output  1  one-cycle read strobe; rom_data is valid the cycle after.
REQ-010 rom_data  input  24  note entry: [23:8] half_period (clocks), [7:0] duration_ms.
REQ-011 tone_half_period  output  16  configuration for the downstream square-wave generator.
REQ-012 tone_valid  output  1  tone_half_period is offered; held until tone_ready.
REQ-013 tone_ready  input  1  generator accepts configuration.
REQ-014 mute  output  1  1 = downstream PWM output forced silent.
REQ-015 busy  output  1  1 in every state except IDLE and DONE.
REQ-016 done  output  1  one-cycle pulse on song completion (non-loop).

Function
REQ-017 States: IDLE, FETCH, LOAD, ISSUE, PLAY, GAP, DONE.
REQ-018 IDLE: mute=1, rom_addr=0; SW rising edge (registered previous SW) -> FETCH.
REQ-019 FETCH: rom_rd=1 for exactly one cycle at rom_addr -> LOAD.
REQ-020 LOAD: capture rom_data into internal period/duration registers; duration==0 (end marker) -> end-of-song handling; half_period==0 (rest) -> PLAY with mute=1, no issue; else -> ISSUE.
REQ-021 ISSUE: tone_valid=1, tone_half_period=captured period, mute=1; tone_valid and tone_half_period SHALL stay stable until the cycle tone_ready=1; on that handshake -> PLAY.
REQ-022 PLAY: mute=0 (1 for a rest); lasts exactly duration_ms*TICK_DIV cycles; the ms prescaler and ms counter SHALL clear on state entry.
REQ-023 PLAY exit: GAP_MS>0 -> GAP, else advance address and -> FETCH.
REQ-024 GAP: mute=1 for exactly GAP_MS*TICK_DIV cycles, then advance address -> FETCH.
REQ-025 Address advance: rom_addr+1; from 2**AW-1, wrap-around SHALL be treated as end-of-song.
REQ-026 End-of-song: loop_en=1 -> rom_addr=0, FETCH; loop_en=0 -> DONE, done=1 on DONE-entry cycle only.
REQ-027 DONE: mute=1; stays until SW=0, then -> IDLE; no retrigger while SW remains high.
REQ-028 SW=0 in any busy state: next cycle -> IDLE, tone_valid=0, mute=1, rom_addr=0; done not asserted.
REQ-029 SW=0 and tone_ready=1 in the same ISSUE cycle: abort wins, state -> IDLE.
REQ-030 loop_en is sampled only at end-of-song.
REQ-031 tone_valid SHALL never be asserted outside ISSUE.

Reset
REQ-032 BTNC=1 at a rising edge: state IDLE, rom_addr=0, rom_rd=0, tone_valid=0, tone_half_period=0, mute=1, busy=0, done=0, counters 0, SW edge register = current SW.
REQ-033 Reset mid-note overrides all inputs; no done pulse; after release, SW already high SHALL NOT start playback without a fresh 0->1 edge.

Verification (TICK_DIV=10, GAP_MS=2, AW=2)
REQ-034 ROM {0x0100,3},{0x0200,1},{0,0}; SW 0->1, tone_ready=1 -> tone_half_period 0x0100 then 0x0200; mute=0 for 30 then 10 cycles, 20-cycle mute gaps; done pulses once; busy=0 after.
REQ-035 tone_ready held low 5 cycles in ISSUE -> tone_valid and 0x0100 stable all 5 cycles; PLAY starts cycle after handshake.
REQ-036 Entry {0x0000,2} (rest) -> no tone_valid, mute=1 for 20 cycles, sequencer advances.
REQ-037 loop_en=1, four non-zero entries -> after address 3, rom_addr wraps to 0, FETCH repeats, done never asserted.
REQ-038 SW dropped mid-PLAY -> next cycle IDLE, mute=1, rom_addr=0; SW re-raised restarts from address 0.
REQ-039 BTNC pulsed mid-GAP with SW held high -> all outputs at REQ-032 values; no restart until SW toggles 0->1.
